// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for full_cpu bring-up.
// Sequences the core reset, counts RUN cycles and retired instructions, and
// ends the run on an ECALL retire, a store to TOHOST_ADDR or a cycle-budget
// timeout. All outputs are registered.
// Optional macro CPU_RUN_STALL_WATCHDOG_EN adds a no-retire stall watchdog
// and the stall_flag output.
module cpu_run_ctrl #(
    parameter int          RESET_CYCLES = 1,
    parameter int          MAX_CYCLES   = 10,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FFC,
    parameter int          STALL_LIMIT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             cpu_reset,
    input  logic             retire_valid,
    input  logic [31:0]      retire_instr,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
`ifdef CPU_RUN_STALL_WATCHDOG_EN
    ,
    output logic             stall_flag
`endif
);

    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
    // Hold counter only needs to represent RESET_CYCLES-1.
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [31:0]       exit_q, exit_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;

    logic              tohost_hit;
    logic              ecall_hit;
    logic              budget_hit;

`ifdef CPU_RUN_STALL_WATCHDOG_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stall_flag_q, stall_flag_d;
    logic               stall_hit;

    // A stall ends the run on the cycle the no-retire count would reach the limit.
    always_comb begin
        stall_hit = !retire_valid && (stall_q == STALL_LAST);
    end
`endif

    // End-of-run events, only meaningful while in RUN.
    always_comb begin
        tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
        ecall_hit  = retire_valid && (retire_instr == ECALL_INSTR);
        budget_hit = (cycle_q == BUDGET_LAST);
    end

    // Next-state, counters and flags; outputs are derived from the next state
    // so they can be registered alongside it.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        exit_d    = exit_q;
        done_d    = done_q;
        timeout_d = timeout_q;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
        stall_d      = stall_q;
        stall_flag_d = stall_flag_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d   = S_HOLD;
                    hold_d    = HOLD_INIT;
                    cycle_d   = '0;
                    instret_d = '0;
                    exit_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
                    stall_d      = '0;
                    stall_flag_d = 1'b0;
`endif
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (cycle_q != CNT_MAX) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
                if (retire_valid && (instret_q != CNT_MAX)) begin
                    instret_d = instret_q + CNT_W'(1);
                end
`ifdef CPU_RUN_STALL_WATCHDOG_EN
                stall_d = retire_valid ? '0 : (stall_q + STALL_W'(1));
`endif
                if (tohost_hit) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    exit_d  = mem_wdata;
                end else if (ecall_hit) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    exit_d  = '0;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
                end else if (stall_hit) begin
                    state_d      = S_FIN;
                    timeout_d    = 1'b1;
                    stall_flag_d = 1'b1;
`endif
                end else if (budget_hit) begin
                    state_d   = S_FIN;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_reset_d = (state_d != S_RUN);
        running_d   = (state_d == S_RUN);
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
            exit_q      <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
            stall_q      <= '0;
            stall_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            exit_q      <= exit_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
            stall_q      <= stall_d;
            stall_flag_q <= stall_flag_d;
`endif
        end
    end

    assign cpu_reset     = cpu_reset_q;
    assign running       = running_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign exit_code     = exit_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
    assign stall_flag    = stall_flag_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: two controller instances (default parameters and
// RESET_CYCLES=3/MAX_CYCLES=100/STALL_LIMIT=4) checked every cycle against a
// behavioural run model, plus literal expectations for each directed scenario.
// Build with CPU_RUN_STALL_WATCHDOG_EN defined to include the stall scenario.
module tb_cpu_run_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] ADD    = 32'h0020_81B3;
    localparam logic [31:0] TOHOST = 32'h0000_0FFC;
    localparam longint      CMAX   = 64'h0000_0000_FFFF_FFFF;

    localparam int A_RC = 1, A_MC = 10,  A_SL = 16;
    localparam int B_RC = 3, B_MC = 100, B_SL = 4;

    // Model phases.
    localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_FIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, start_a, reset_b, start_b;
    logic        retire_valid, mem_we;
    logic [31:0] retire_instr, mem_addr, mem_wdata;

    logic        cpu_reset_a, running_a, done_a, timeout_a;
    logic [31:0] exit_a, cyc_a, ins_a;
    logic        cpu_reset_b, running_b, done_b, timeout_b;
    logic [31:0] exit_b, cyc_b, ins_b;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
    logic        stall_a, stall_b;
`endif

    cpu_run_ctrl #(.RESET_CYCLES(A_RC), .MAX_CYCLES(A_MC), .CNT_W(32),
                   .TOHOST_ADDR(TOHOST), .STALL_LIMIT(A_SL)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .cpu_reset(cpu_reset_a),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .running(running_a), .done(done_a), .timeout(timeout_a),
        .exit_code(exit_a), .cycle_count(cyc_a), .instret_count(ins_a)
`ifdef CPU_RUN_STALL_WATCHDOG_EN
        , .stall_flag(stall_a)
`endif
    );

    cpu_run_ctrl #(.RESET_CYCLES(B_RC), .MAX_CYCLES(B_MC), .CNT_W(32),
                   .TOHOST_ADDR(TOHOST), .STALL_LIMIT(B_SL)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .cpu_reset(cpu_reset_b),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .running(running_b), .done(done_b), .timeout(timeout_b),
        .exit_code(exit_b), .cycle_count(cyc_b), .instret_count(ins_b)
`ifdef CPU_RUN_STALL_WATCHDOG_EN
        , .stall_flag(stall_b)
`endif
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int     phase;
        int     hold_left;   // HOLD cycles still to spend
        bit     done;
        bit     timeout;
        bit     stall_flag;
        longint exit_code;
        longint cyc;
        longint ins;
        int     idle_run;    // consecutive RUN cycles without a retire
    } model_t;

    model_t ma, mb;

    function automatic void model_step(inout model_t m, input int rc, input int mc,
                                       input int sl, input bit rst, input bit st,
                                       input bit rv, input logic [31:0] ri,
                                       input bit we, input logic [31:0] addr,
                                       input logic [31:0] wd);
        bit is_tohost, is_ecall, is_last, is_stall;
        is_stall = 1'b0;
        if (rst) begin
            m.phase = P_IDLE; m.hold_left = 0; m.done = 0; m.timeout = 0;
            m.stall_flag = 0; m.exit_code = 0; m.cyc = 0; m.ins = 0; m.idle_run = 0;
            return;
        end
        if (m.phase == P_IDLE || m.phase == P_FIN) begin
            if (st) begin
                m.phase = P_HOLD; m.hold_left = rc; m.done = 0; m.timeout = 0;
                m.stall_flag = 0; m.exit_code = 0; m.cyc = 0; m.ins = 0; m.idle_run = 0;
            end
        end else if (m.phase == P_HOLD) begin
            m.hold_left = m.hold_left - 1;
            if (m.hold_left == 0) m.phase = P_RUN;
        end else begin
            is_tohost = we && (addr == TOHOST);
            is_ecall  = rv && (ri == ECALL);
            is_last   = (m.cyc + 1 == mc);
            m.cyc = (m.cyc + 1 > CMAX) ? CMAX : m.cyc + 1;
            if (rv) m.ins = (m.ins + 1 > CMAX) ? CMAX : m.ins + 1;
            m.idle_run = rv ? 0 : m.idle_run + 1;
`ifdef CPU_RUN_STALL_WATCHDOG_EN
            is_stall = (m.idle_run >= sl);
`endif
            if (is_tohost) begin
                m.phase = P_FIN; m.done = 1; m.exit_code = wd;
            end else if (is_ecall) begin
                m.phase = P_FIN; m.done = 1; m.exit_code = 0;
            end else if (is_stall) begin
                m.phase = P_FIN; m.timeout = 1; m.stall_flag = 1;
            end else if (is_last) begin
                m.phase = P_FIN; m.timeout = 1;
            end
        end
    endfunction

    always @(posedge clk) begin
        model_step(ma, A_RC, A_MC, A_SL, reset_a, start_a, retire_valid, retire_instr,
                   mem_we, mem_addr, mem_wdata);
        model_step(mb, B_RC, B_MC, B_SL, reset_b, start_b, retire_valid, retire_instr,
                   mem_we, mem_addr, mem_wdata);
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, both DUTs must agree with their model.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("a.cpu_reset", 64'(cpu_reset_a), 64'(ma.phase != P_RUN));
            cmp("a.running",   64'(running_a),   64'(ma.phase == P_RUN));
            cmp("a.done",      64'(done_a),      64'(ma.done));
            cmp("a.timeout",   64'(timeout_a),   64'(ma.timeout));
            cmp("a.exit_code", 64'(exit_a),      ma.exit_code);
            cmp("a.cycles",    64'(cyc_a),       ma.cyc);
            cmp("a.instret",   64'(ins_a),       ma.ins);
            cmp("b.cpu_reset", 64'(cpu_reset_b), 64'(mb.phase != P_RUN));
            cmp("b.running",   64'(running_b),   64'(mb.phase == P_RUN));
            cmp("b.done",      64'(done_b),      64'(mb.done));
            cmp("b.timeout",   64'(timeout_b),   64'(mb.timeout));
            cmp("b.exit_code", 64'(exit_b),      mb.exit_code);
            cmp("b.cycles",    64'(cyc_b),       mb.cyc);
            cmp("b.instret",   64'(ins_b),       mb.ins);
`ifdef CPU_RUN_STALL_WATCHDOG_EN
            cmp("a.stall_flag", 64'(stall_a), 64'(ma.stall_flag));
            cmp("b.stall_flag", 64'(stall_b), 64'(mb.stall_flag));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge: sets inputs for the next rising edge, then
    // returns at the following falling edge.
    task automatic drive(input bit sa, input bit sb, input bit rv, input logic [31:0] ri,
                         input bit we, input logic [31:0] addr, input logic [31:0] wd);
        start_a = sa; start_b = sb; retire_valid = rv; retire_instr = ri;
        mem_we = we; mem_addr = addr; mem_wdata = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // Counts HOLD cycles until the chosen DUT reports running; optionally
    // pulses start during HOLD (which must be ignored).
    task automatic wait_running(input bit which_b, input bit poke, output int holds);
        holds = 0;
        while (!(which_b ? running_b : running_a) && holds < 50) begin
            drive(!which_b && poke, which_b && poke, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            holds++;
        end
        if (holds >= 50) cmp("wait_running_bound", 64'(holds), 64'd0);
    endtask

    // Counts RUN cycles with no core activity until the run ends.
    task automatic count_running(input bit which_b, output int n);
        n = 0;
        while ((which_b ? running_b : running_a) && n < 300) begin
            idle(1);
            n++;
        end
        if (n >= 300) cmp("count_running_bound", 64'(n), 64'd0);
    endtask

    initial begin
        int h, n;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; retire_valid = 1'b0; retire_instr = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        // Reset values.
        cmp("rst.cpu_reset", 64'(cpu_reset_a), 64'd1);
        cmp("rst.running",   64'(running_a),   64'd0);
        cmp("rst.done",      64'(done_a),      64'd0);
        cmp("rst.timeout",   64'(timeout_a),   64'd0);
        cmp("rst.exit",      64'(exit_a),      64'd0);
        cmp("rst.cycles",    64'(cyc_a),       64'd0);
        cmp("rst.instret",   64'(ins_b),       64'd0);
        reset_a = 1'b0; reset_b = 1'b0;
        idle(1);

        // T1: default parameters, no retires -> budget timeout.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b0, 1'b0, h);
        cmp("t1.hold_cycles", 64'(h), 64'd1);
        count_running(1'b0, n);
        cmp("t1.run_cycles", 64'(n), 64'd10);
        cmp("t1.timeout", 64'(timeout_a), 64'd1);
        cmp("t1.done",    64'(done_a),    64'd0);
        cmp("t1.cycles",  64'(cyc_a),     64'd10);
        cmp("t1.cpu_reset_fin", 64'(cpu_reset_a), 64'd1);

        // T2: RESET_CYCLES=3, start pulsed during HOLD, 5 ADDs then ECALL.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b1, 1'b1, h);
        cmp("t2.hold_cycles", 64'(h), 64'd3);
        repeat (5) drive(1'b0, 1'b0, 1'b1, ADD, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        cmp("t2.done",    64'(done_b),    64'd1);
        cmp("t2.timeout", 64'(timeout_b), 64'd0);
        cmp("t2.instret", 64'(ins_b),     64'd6);
        cmp("t2.exit",    64'(exit_b),    64'd0);
        cmp("t2.cycles",  64'(cyc_b),     64'd6);

        // T3: TOHOST store and ECALL in the same cycle; TOHOST wins.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b1, 1'b0, h);
        repeat (2) drive(1'b0, 1'b0, 1'b1, ADD, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, ECALL, 1'b1, TOHOST, 32'h2A);
        cmp("t3.done",    64'(done_b),    64'd1);
        cmp("t3.exit",    64'(exit_b),    64'h2A);
        cmp("t3.timeout", 64'(timeout_b), 64'd0);
        cmp("t3.instret", 64'(ins_b),     64'd3);

        // T4: store to a non-TOHOST address and start during RUN are ignored.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b0, 1'b0, h);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0FF8, 32'h55);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        count_running(1'b0, n);
        cmp("t4.run_cycles", 64'(n + 2), 64'd10);
        cmp("t4.timeout", 64'(timeout_a), 64'd1);
        cmp("t4.done",    64'(done_a),    64'd0);
        cmp("t4.exit",    64'(exit_a),    64'd0);

        // T5: ECALL on the last budget cycle -> done, not timeout.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b0, 1'b0, h);
        idle(9);
        drive(1'b0, 1'b0, 1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        cmp("t5.done",    64'(done_a),    64'd1);
        cmp("t5.timeout", 64'(timeout_a), 64'd0);
        cmp("t5.cycles",  64'(cyc_a),     64'd10);
        cmp("t5.instret", 64'(ins_a),     64'd1);

        // T6: reset mid-RUN overrides start/ECALL/TOHOST; a later run is clean.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b0, 1'b0, h);
        idle(4);
        cmp("t6.cycles_before_reset", 64'(cyc_a), 64'd4);
        reset_a = 1'b1;
        drive(1'b1, 1'b0, 1'b1, ECALL, 1'b1, TOHOST, 32'h77);
        reset_a = 1'b0;
        cmp("t6.cpu_reset", 64'(cpu_reset_a), 64'd1);
        cmp("t6.running",   64'(running_a),   64'd0);
        cmp("t6.cycles",    64'(cyc_a),       64'd0);
        cmp("t6.done",      64'(done_a),      64'd0);
        cmp("t6.exit",      64'(exit_a),      64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b0, 1'b0, h);
        cmp("t6.hold_cycles", 64'(h), 64'd1);
        drive(1'b0, 1'b0, 1'b1, ADD, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, ECALL, 1'b0, 32'h0, 32'h0);
        cmp("t6.done2",    64'(done_a), 64'd1);
        cmp("t6.instret2", 64'(ins_a),  64'd2);
        cmp("t6.cycles2",  64'(cyc_a),  64'd2);

`ifdef CPU_RUN_STALL_WATCHDOG_EN
        // T7: STALL_LIMIT=4, two retires then nothing -> stall timeout.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_running(1'b1, 1'b0, h);
        repeat (2) drive(1'b0, 1'b0, 1'b1, ADD, 1'b0, 32'h0, 32'h0);
        count_running(1'b1, n);
        cmp("t7.idle_cycles", 64'(n),         64'd4);
        cmp("t7.timeout",     64'(timeout_b), 64'd1);
        cmp("t7.stall_flag",  64'(stall_b),   64'd1);
        cmp("t7.done",        64'(done_b),    64'd0);
        cmp("t7.instret",     64'(ins_b),     64'd2);
`endif

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller that wraps full_cpu bring-up.
- Sequences the core's reset, counts cycles and retired instructions, and detects program end.
- Program end is an ECALL retire or a store to a TOHOST address; a cycle-budget timeout also ends the run.
- Replaces fixed-delay bench timing with a parametrised, self-terminating run, usable both in the bench and on FPGA.

Parameters:
- RESET_CYCLES, 1, cycles cpu_reset is held high after start (≥1).
- MAX_CYCLES, 10, cycle budget in RUN before timeout (≥1).
- CNT_W, 32, width of the cycle and instret counters.
- TOHOST_ADDR, 32'h0000_0FFC, store address that ends the run.
- STALL_LIMIT, 16, max consecutive RUN cycles without a retire (only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high controller reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or from a final state.
- cpu_reset  out  1  reset driven to full_cpu.
- retire_valid  in  1  core retired one instruction this cycle.
- retire_instr  in  32  instruction word retired.
- mem_we  in  1  core data-store strobe.
- mem_addr  in  32  store address.
- mem_wdata  in  32  store data.
- running  out  1  state == RUN.
- done  out  1  run ended by ECALL or TOHOST (sticky until start/reset).
- timeout  out  1  run ended by budget or stall (sticky until start/reset).
- exit_code  out  32  TOHOST wdata, or 0 on ECALL/timeout.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instret_count  out  CNT_W  retired instructions in RUN.

Behaviour:
- Reset values: state=IDLE, cpu_reset=1, running=0, done=0, timeout=0, exit_code=0, cycle_count=0, instret_count=0.
- FSM states: IDLE, HOLD, RUN, FIN.
- IDLE: cpu_reset=1. start → HOLD; the hold counter loads RESET_CYCLES-1; both counters and exit_code clear.
- HOLD: cpu_reset=1. Counter decrements each cycle; at 0 → RUN next cycle. cpu_reset is high for exactly RESET_CYCLES cycles after the start edge.
- RUN: cpu_reset=0, running=1. cycle_count increments every cycle; instret_count increments when retire_valid.
- Termination is evaluated on the registered count. The end condition takes effect next edge, state → FIN.
  - ECALL: retire_valid && retire_instr==32'h0000_0073 → done=1, exit_code=0. The ECALL counts in instret_count.
  - TOHOST: mem_we && mem_addr==TOHOST_ADDR → done=1, exit_code=mem_wdata.
  - Budget: cycle_count==MAX_CYCLES-1 with no other end → timeout=1. Final cycle_count=MAX_CYCLES.
- Priority when events coincide in one cycle: TOHOST > ECALL > budget. done and timeout are never both 1.
- FIN: cpu_reset=1 (core frozen). Counters and flags hold. start → HOLD and clears flags, counters and exit_code.
- start while in HOLD or RUN is ignored.
- Counters saturate at all-ones and never wrap.
- reset asserted in any state → all reset values on the next edge, overriding start and retire inputs.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CPU_RUN_STALL_WATCHDOG_EN.
- Defined:
  - A stall counter clears on retire_valid and increments on each RUN cycle without a retire.
  - Reaching STALL_LIMIT → FIN with timeout=1.
  - Adds output stall_flag (1 bit, reset 0), set alongside timeout only for stall terminations.
  - Priority: TOHOST > ECALL > stall > budget.
- Undefined: no stall counter, no stall_flag port; STALL_LIMIT is unused.

Test Plan:
- Defaults; start at cycle 2; no retires → cpu_reset high 1 cycle, running 10 cycles, timeout=1, cycle_count=10, done=0.
- RESET_CYCLES=3, MAX_CYCLES=100; start; core retires 5 ADDs then ECALL → cpu_reset high 3 cycles after start, done=1, instret_count=6, exit_code=0.
- Store mem_addr=32'h0FFC, wdata=32'h2A, with an ECALL retiring the same cycle → done=1, exit_code=32'h2A, timeout=0.
- Store to 32'h0FF8 → no termination; run continues to budget timeout.
- reset pulsed mid-RUN at cycle 4 → next edge: IDLE, cpu_reset=1, counters 0. A later start runs cleanly.
- With CPU_RUN_STALL_WATCHDOG_EN, STALL_LIMIT=4: 2 retires then none → timeout=1 and stall_flag=1 after 4 idle RUN cycles, instret_count=2.
